switch_egress_port: RTL and testbench
=====================================

# switch_egress_port

Egress side of the packet switch: it collects single-cycle packets from all `NUM_PORTS` ingress ports and keeps those whose target mask selects this port. Accepted packets are buffered in one holding slot per source. A round-robin arbiter drains the slots into an output FIFO, and the FIFO is delivered downstream over a valid/ready handshake. There is one instance per switch output, fed in parallel by the registered outputs of every ingress port.

## Interface
- `NUM_PORTS`, 4: number of ingress ports, 2..4.
- `PORT_ID`, 0: index of this egress port; selects bit `PORT_ID` of the target mask.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, at least 2.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  NUM_PORTS  per-ingress packet strobe; one cycle per packet; no backpressure.
- `source_in`  in  NUM_PORTS*4  per-ingress source mask, flattened; ingress i occupies bits [4i+3:4i].
- `target_in`  in  NUM_PORTS*4  per-ingress target mask (multicast allowed), flattened the same way.
- `data_in`  in  NUM_PORTS*8  per-ingress payload, flattened; ingress i occupies bits [8i+7:8i].
- `valid_out`  out  1  FIFO head valid.
- `ready_in`  in  1  downstream accepts the head when high together with `valid_out`.
- `source_out`  out  4  source mask of the head.
- `target_out`  out  4  target mask of the head.
- `data_out`  out  8  payload of the head.
- `drop_count`  out  8  saturating count of packets lost to slot overflow.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Match: ingress i hits when `valid_in[i] && target_in[4i+PORT_ID]`. Non-matching packets are ignored and not counted.
- Holding slot i: one entry (source, target, data) plus a `full` flag.
  - A hit loads the slot if the slot is empty, or if the slot is being drained in the same cycle.
  - Otherwise the packet is dropped and `drop_count` increments. The count saturates at 255.
  - Several ingress ports can drop in the same cycle. `drop_count` then adds the number of drops, saturating at 255.
- Arbiter: round-robin over slots whose `full` flag is set.
  - The pointer `rr_ptr` resets to 0.
  - The search starts at `rr_ptr`. After a grant to slot g, `rr_ptr` becomes (g+1) mod `NUM_PORTS`.
  - At most one grant per cycle, and only when the FIFO can accept a push (not full, or a pop occurs in the same cycle).
  - With no grant, `rr_ptr` holds.
- FIFO: a grant pushes the slot contents and clears the slot's `full` flag.
  - Pop occurs on `valid_out && ready_in`.
  - Push and pop in the same cycle are legal at any level, including full and empty.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- Outputs come from the FIFO head and are held stable while `valid_out && !ready_in`.
- Reset, asynchronous and allowed at any time:
  - all slots and the FIFO empty;
  - `valid_out`=0, `source_out`=0, `target_out`=0, `data_out`=0;
  - `drop_count`=0, `fifo_level`=0, `rr_ptr`=0.
  - In-flight packets are discarded.

## Timing
- Cycle N: hit on `valid_in`; the slot is loaded at the edge ending N.
- Cycle N+1: slot granted; FIFO push at the edge ending N+1.
- Cycle N+2: `valid_out`=1 with the packet. Minimum latency is 2 cycles.
- Throughput: one packet per cycle at the output. Slot-to-FIFO transfer is limited to one per cycle.
- With FIFO full and `ready_in`=0, slots hold and no grants occur. New hits into full slots are dropped.
- Hit into slot i in the same cycle slot i is granted: the old packet moves to the FIFO, the new one is captured, and there is no drop.
- `drop_count` and `fifo_level` are registered and update at the edge following the event.

## Structure
- Package `switch_pkg`:
  - `PORT_W`=4, `DATA_W`=8;
  - `packet_t` struct {source, target, data};
  - helper function `rr_pick(req, ptr)` that returns the grant index and a grant-valid flag.
- Sub-module `switch_sync_fifo` (parameters WIDTH, DEPTH):
  - registered storage;
  - `count`, `full`, `empty` outputs;
  - simultaneous push/pop supported.
- The top level holds the slots, the arbiter, the drop counter and the output mapping.

## Test plan
- Single packet: ingress 2 sends source=4'b0100, target=4'b0001, data=8'hA5 to `PORT_ID`=0, with `ready_in`=1.
  - Required: `valid_out` rises exactly 2 cycles later with those values, for one cycle.
  - Required: `drop_count`=0.
- Filtering: ingress 1 sends target=4'b0010 to `PORT_ID`=0.
  - Required: `valid_out` never asserts and `drop_count` stays 0.
- Round-robin: ingress 0..3 all hit in one cycle with data 8'h10..8'h13, and `ready_in`=1.
  - Required: output order is 10, 11, 12, 13 on consecutive cycles.
  - Repeat with `rr_ptr` at 2. Required order: 12, 13, 10, 11.
- Backpressure and drop: `FIFO_DEPTH`=4, `ready_in`=0, ingress 0 sends 6 packets on consecutive cycles.
  - Required: `fifo_level` reaches 4 and slot 0 holds one packet, so `drop_count`=1.
  - Then raise `ready_in`. Required: the 5 surviving packets exit in order.
- Saturation: 300 drops forced via ingress 3 with the FIFO stalled.
  - Required: `drop_count` stops at 255.
- Reset mid-stream: assert `rst_n`=0 while the FIFO holds 3 packets.
  - Required: `valid_out`, `fifo_level` and `drop_count` go to 0 asynchronously.
  - Required: after release, a new packet appears with 2-cycle latency.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types and helpers for the switch egress path.
package switch_pkg;

    localparam int unsigned PORT_W    = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_PORTS = 4;
    localparam int unsigned IDX_W     = 2;

    typedef struct packed {
        logic [PORT_W-1:0] source;
        logic [PORT_W-1:0] target;
        logic [DATA_W-1:0] data;
    } packet_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_grant_t;

    // Round-robin search starting at ptr; unpopulated request bits are simply skipped.
    function automatic rr_grant_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                          input logic [IDX_W-1:0]     ptr);
        rr_grant_t        g;
        logic [IDX_W-1:0] cand;
        g = '0;
        for (int unsigned k = 0; k < MAX_PORTS; k++) begin
            cand = ptr + IDX_W'(k);
            if (!g.valid && req[cand]) begin
                g.valid = 1'b1;
                g.idx   = cand;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/switch_sync_fifo.sv
// Synchronous FIFO with a registered head word and registered status flags.
module switch_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic [WIDTH-1:0]            head_q, head_d;
    logic                        full_q, full_d;
    logic                        empty_q, empty_d;
    logic                        push_ok, pop_ok;

    // Head is precomputed for the next cycle so rdata_o comes straight from a flop.
    always_comb begin
        pop_ok   = pop_i && !empty_q;
        push_ok  = push_i && (!full_q || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
        head_d   = (push_ok && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata_o = head_q;
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/switch_egress_port.sv
// Egress port: filters ingress packets by target mask, buffers one per source,
// and drains the slots round-robin into an output FIFO with valid/ready delivery.
module switch_egress_port
    import switch_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned PORT_ID    = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          valid_in,
    input  logic [NUM_PORTS*PORT_W-1:0]   source_in,
    input  logic [NUM_PORTS*PORT_W-1:0]   target_in,
    input  logic [NUM_PORTS*DATA_W-1:0]   data_in,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic [PORT_W-1:0]             source_out,
    output logic [PORT_W-1:0]             target_out,
    output logic [DATA_W-1:0]             data_out,
    output logic [7:0]                    drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned DROP_W = 8;
    localparam int unsigned SUM_W  = DROP_W + 1;
    localparam int unsigned PKT_W  = $bits(packet_t);

    logic [NUM_PORTS-1:0]            hit;
    packet_t [NUM_PORTS-1:0]         in_pkt;
    packet_t [NUM_PORTS-1:0]         slot_q, slot_d;
    logic [NUM_PORTS-1:0]            full_q, full_d;
    logic [NUM_PORTS-1:0]            drain;
    logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [DROP_W-1:0]               drop_q, drop_d;
    logic [SUM_W-1:0]                drop_sum;
    logic [2:0]                      n_drop;
    logic [MAX_PORTS-1:0]            req;
    rr_grant_t                       pick;
    logic                            grant;
    packet_t                         push_pkt;
    packet_t                         fifo_head;
    logic                            fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]     fifo_count;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
        assign hit[gi]    = valid_in[gi] && target_in[PORT_W*gi + PORT_ID];
        assign in_pkt[gi] = '{source: source_in[PORT_W*gi +: PORT_W],
                              target: target_in[PORT_W*gi +: PORT_W],
                              data:   data_in[DATA_W*gi +: DATA_W]};
    end

    // A slot being granted this cycle can take a new hit without dropping it.
    always_comb begin
        req                  = '0;
        req[NUM_PORTS-1:0]   = full_q;
        fifo_pop             = !fifo_empty && ready_in;
        pick                 = rr_pick(req, rr_ptr_q);
        grant                = pick.valid && (!fifo_full || fifo_pop);
        slot_d               = slot_q;
        full_d               = full_q;
        drain                = '0;
        push_pkt             = '0;
        n_drop               = '0;
        rr_ptr_d             = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (pick.idx == IDX_W'(i)) begin
                push_pkt = slot_q[i];
            end
            drain[i] = grant && (pick.idx == IDX_W'(i));
            if (hit[i] && (!full_q[i] || drain[i])) begin
                slot_d[i] = in_pkt[i];
                full_d[i] = 1'b1;
            end else begin
                if (drain[i]) begin
                    full_d[i] = 1'b0;
                end
                if (hit[i]) begin
                    n_drop = n_drop + 3'd1;
                end
            end
        end
        if (grant) begin
            rr_ptr_d = (pick.idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick.idx + IDX_W'(1);
        end
        drop_sum = {1'b0, drop_q} + SUM_W'(n_drop);
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            full_q   <= '0;
            rr_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            slot_q   <= slot_d;
            full_q   <= full_d;
            rr_ptr_q <= rr_ptr_d;
            drop_q   <= drop_d;
        end
    end

    switch_sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (grant),
        .wdata_i (push_pkt),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign valid_out  = !fifo_empty;
    assign source_out = fifo_head.source;
    assign target_out = fifo_head.target;
    assign data_out   = fifo_head.data;
    assign drop_count = drop_q;
    assign fifo_level = fifo_count;

endmodule

// File: tb/tb_switch_egress_port.sv
// Directed bench for switch_egress_port (4 ports, PORT_ID 0, FIFO depth 4).
module tb_switch_egress_port;

    logic        clk;
    logic        rst_n;
    logic [3:0]  valid_in;
    logic [15:0] source_in;
    logic [15:0] target_in;
    logic [31:0] data_in;
    logic        valid_out;
    logic        ready_in;
    logic [3:0]  source_out;
    logic [3:0]  target_out;
    logic [7:0]  data_out;
    logic [7:0]  drop_count;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]       vin;
        logic [15:0]      tgt;
        logic [31:0]      dat;
        logic [2:0]       n;
        logic [3:0][7:0]  ed;
        logic [3:0][3:0]  es;
        logic [3:0][3:0]  et;
    } vec_t;

    vec_t vecs [6];

    switch_egress_port #(
        .NUM_PORTS  (4),
        .PORT_ID    (0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .source_in  (source_in),
        .target_in  (target_in),
        .data_in    (data_in),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .source_out (source_out),
        .target_out (target_out),
        .data_out   (data_out),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in  = '0;
        target_in = '0;
        data_in   = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        ready_in  = 1'b1;
        source_in = 16'h8421;
        idle_inputs();

        // port order: vin/tgt/dat flattened ingress3..0; expected lists are first-out at index 0
        vecs[0] = '{vin: 4'b1111, tgt: 16'h1111, dat: 32'h13121110, n: 3'd4,
                    ed: {8'h13, 8'h12, 8'h11, 8'h10}, es: {4'h8, 4'h4, 4'h2, 4'h1},
                    et: {4'h1, 4'h1, 4'h1, 4'h1}};
        vecs[1] = '{vin: 4'b0010, tgt: 16'h0010, dat: 32'h00002100, n: 3'd1,
                    ed: {8'h00, 8'h00, 8'h00, 8'h21}, es: {4'h0, 4'h0, 4'h0, 4'h2},
                    et: {4'h0, 4'h0, 4'h0, 4'h1}};
        vecs[2] = '{vin: 4'b1111, tgt: 16'h1111, dat: 32'h13121110, n: 3'd4,
                    ed: {8'h11, 8'h10, 8'h13, 8'h12}, es: {4'h2, 4'h1, 4'h8, 4'h4},
                    et: {4'h1, 4'h1, 4'h1, 4'h1}};
        vecs[3] = '{vin: 4'b0100, tgt: 16'h0100, dat: 32'h00A50000, n: 3'd1,
                    ed: {8'h00, 8'h00, 8'h00, 8'hA5}, es: {4'h0, 4'h0, 4'h0, 4'h4},
                    et: {4'h0, 4'h0, 4'h0, 4'h1}};
        vecs[4] = '{vin: 4'b0010, tgt: 16'h0020, dat: 32'h00003300, n: 3'd0,
                    ed: '0, es: '0, et: '0};
        vecs[5] = '{vin: 4'b1011, tgt: 16'hF143, dat: 32'h44332211, n: 3'd2,
                    ed: {8'h00, 8'h00, 8'h11, 8'h44}, es: {4'h0, 4'h0, 4'h1, 4'h8},
                    et: {4'h0, 4'h0, 4'h3, 4'hF}};

        tick();
        tick();
        chk("reset valid_out", 32'(valid_out), 32'd0);
        chk("reset fifo_level", 32'(fifo_level), 32'd0);
        chk("reset drop_count", 32'(drop_count), 32'd0);
        chk("reset head", {20'd0, source_out, target_out, data_out}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single-cycle bursts with ready high: exact 2-cycle latency and RR order
        for (int v = 0; v < 6; v++) begin
            valid_in  = vecs[v].vin;
            target_in = vecs[v].tgt;
            data_in   = vecs[v].dat;
            for (int j = 1; j <= 8; j++) begin
                tick();
                if (j == 1) idle_inputs();
                if ((j - 2) >= 0 && (j - 2) < int'(vecs[v].n)) begin
                    chk($sformatf("vec%0d out%0d valid", v, j - 2), 32'(valid_out), 32'd1);
                    chk($sformatf("vec%0d out%0d data", v, j - 2), 32'(data_out),
                        32'(vecs[v].ed[j - 2]));
                    chk($sformatf("vec%0d out%0d source", v, j - 2), 32'(source_out),
                        32'(vecs[v].es[j - 2]));
                    chk($sformatf("vec%0d out%0d target", v, j - 2), 32'(target_out),
                        32'(vecs[v].et[j - 2]));
                end else begin
                    chk($sformatf("vec%0d cyc%0d idle", v, j), 32'(valid_out), 32'd0);
                end
            end
            chk($sformatf("vec%0d drop_count", v), 32'(drop_count), 32'd0);
        end

        // Backpressure: six packets into slot 0, FIFO fills, one dropped
        ready_in = 1'b0;
        for (int c = 0; c < 6; c++) begin
            valid_in  = 4'b0001;
            target_in = 16'h0001;
            data_in   = 32'(8'h60 + c);
            tick();
        end
        idle_inputs();
        chk("bp fifo_level full", 32'(fifo_level), 32'd4);
        chk("bp drop_count", 32'(drop_count), 32'd1);
        chk("bp head held", 32'(data_out), 32'h60);
        tick();
        chk("bp head stable", 32'(data_out), 32'h60);
        chk("bp valid stable", 32'(valid_out), 32'd1);
        ready_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp drain%0d valid", k), 32'(valid_out), 32'd1);
            chk($sformatf("bp drain%0d data", k), 32'(data_out), 32'(8'h60 + k));
            tick();
        end
        chk("bp drained valid", 32'(valid_out), 32'd0);
        chk("bp drained level", 32'(fifo_level), 32'd0);

        // Multi-drop accumulation and saturation with the FIFO stalled
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        ready_in = 1'b0;
        tick();
        valid_in  = 4'b1111;
        target_in = 16'h1111;
        data_in   = 32'h77665544;
        repeat (6) tick();
        chk("multi drop_count", 32'(drop_count), 32'd16);
        chk("multi fifo_level", 32'(fifo_level), 32'd4);
        valid_in = 4'b1000;
        repeat (237) tick();
        chk("sat pre drop_count", 32'(drop_count), 32'd253);
        valid_in = 4'b1111;
        tick();
        chk("sat sum clamp", 32'(drop_count), 32'd255);
        valid_in = 4'b1000;
        repeat (70) tick();
        chk("sat hold", 32'(drop_count), 32'd255);
        idle_inputs();

        // Reset mid-stream with three packets queued
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        valid_in  = 4'b0011;
        target_in = 16'h0011;
        data_in   = 32'h0000B1A1;
        tick();
        valid_in  = 4'b0001;
        target_in = 16'h0001;
        data_in   = 32'h000000A2;
        tick();
        data_in   = 32'h000000A3;
        tick();
        idle_inputs();
        tick();
        chk("mid fifo_level", 32'(fifo_level), 32'd3);
        chk("mid drop_count", 32'(drop_count), 32'd1);
        chk("mid head", 32'(data_out), 32'hA1);
        rst_n = 1'b0;
        #1;
        chk("async valid_out", 32'(valid_out), 32'd0);
        chk("async fifo_level", 32'(fifo_level), 32'd0);
        chk("async drop_count", 32'(drop_count), 32'd0);
        chk("async data_out", 32'(data_out), 32'd0);
        tick();
        rst_n    = 1'b1;
        ready_in = 1'b1;
        valid_in  = 4'b0100;
        target_in = 16'h0100;
        data_in   = 32'h00C70000;
        tick();
        idle_inputs();
        chk("post rst cyc1 idle", 32'(valid_out), 32'd0);
        tick();
        chk("post rst valid", 32'(valid_out), 32'd1);
        chk("post rst data", 32'(data_out), 32'hC7);
        chk("post rst source", 32'(source_out), 32'h4);
        tick();
        chk("post rst one cycle", 32'(valid_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
